// File: rtl/myproject_sdiv_26s_12s_14_seq_if.sv
// Block-level handshake and operand/result bundle for the sequential signed divider.
// The master drives the request and operands; the slave (divider) returns status and results.
interface myproject_sdiv_26s_12s_14_seq_if #(
   parameter int din0_WIDTH = 26,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 14
);
   logic                  ap_start;
   logic                  ap_ready;
   logic                  ap_idle;
   logic                  ap_done;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic [dout_WIDTH-1:0] dout;
   logic [din1_WIDTH-1:0] rem;
   logic                  ovf;
   logic                  div0;

   modport master (
      output ap_start, din0, din1,
      input  ap_ready, ap_idle, ap_done, dout, rem, ovf, div0
   );

   modport slave (
      input  ap_start, din0, din1,
      output ap_ready, ap_idle, ap_done, dout, rem, ovf, div0
   );
endinterface

// File: rtl/myproject_sdiv_26s_12s_14_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock.
// Define MYPROJECT_SDIV_SAT_EN to saturate the quotient on overflow/divide-by-zero instead of wrapping.
module myproject_sdiv_26s_12s_14_seq #(
   parameter int din0_WIDTH = 26,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 14
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   myproject_sdiv_26s_12s_14_seq_if.slave bus
);

   localparam int CW = $clog2(din0_WIDTH);
   localparam int PW = din1_WIDTH + 1;
   localparam logic [CW-1:0]         LAST_CNT    = CW'(din0_WIDTH - 1);
   localparam logic [CW-1:0]         ONE_CNT     = CW'(1);
   localparam logic [din0_WIDTH-1:0] ONE_DVD     = din0_WIDTH'(1);
   localparam logic [din1_WIDTH-1:0] ONE_DSR     = din1_WIDTH'(1);
   localparam logic [dout_WIDTH-1:0] ONE_Q       = dout_WIDTH'(1);
   localparam logic [din0_WIDTH-1:0] MAG_POS_LIM = din0_WIDTH'((2 ** (dout_WIDTH - 1)) - 1);
   localparam logic [din0_WIDTH-1:0] MAG_NEG_LIM = din0_WIDTH'(2 ** (dout_WIDTH - 1));
`ifdef MYPROJECT_SDIV_SAT_EN
   localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
   localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [din0_WIDTH-1:0] dvd_q, dvd_d;
   logic [din0_WIDTH-1:0] quo_q, quo_d;
   logic [PW-1:0]         prem_q, prem_d;
   logic [din1_WIDTH-1:0] dsr_q, dsr_d;
   logic                  qneg_q, qneg_d;
   logic                  dneg_q, dneg_d;
   logic [dout_WIDTH-1:0] dout_q, dout_d;
   logic [din1_WIDTH-1:0] rem_q, rem_d;
   logic                  ovf_q, ovf_d;
   logic                  div0_q, div0_d;

   logic [PW:0]           shifted_s;
   logic [PW:0]           trial_s;
   logic [dout_WIDTH-1:0] wrap_s;
   logic [din1_WIDTH-1:0] rmag_s;
   logic [din1_WIDTH-1:0] rem_fix_s;
   logic                  ovf_raw_s;
   logic                  zero_s;
   logic [dout_WIDTH-1:0] dout_fix_s;
   logic [din1_WIDTH-1:0] rem_out_s;
   logic                  ovf_out_s;
   logic                  div0_out_s;

   assign bus.ap_idle  = (state_q == S_IDLE);
   assign bus.ap_ready = (state_q == S_IDLE) & bus.ap_start;
   assign bus.ap_done  = (state_q == S_DONE);
   assign bus.dout     = dout_q;
   assign bus.rem      = rem_q;
   assign bus.ovf      = ovf_q;
   assign bus.div0     = div0_q;

   // One restoring step: the trial subtraction's sign bit decides the quotient bit.
   always_comb begin
      shifted_s = {prem_q, dvd_q[din0_WIDTH-1]};
      trial_s   = shifted_s - {2'b00, dsr_q};
   end

   // Sign application plus overflow and divide-by-zero resolution for the final result.
   always_comb begin
      if (qneg_q) begin
         wrap_s    = ~quo_q[dout_WIDTH-1:0] + ONE_Q;
         ovf_raw_s = (quo_q > MAG_NEG_LIM);
      end else begin
         wrap_s    = quo_q[dout_WIDTH-1:0];
         ovf_raw_s = (quo_q > MAG_POS_LIM);
      end
      rmag_s = prem_q[din1_WIDTH-1:0];
      if (dneg_q) begin
         rem_fix_s = ~rmag_s + ONE_DSR;
      end else begin
         rem_fix_s = rmag_s;
      end
      zero_s = (dsr_q == {din1_WIDTH{1'b0}});

      dout_fix_s = wrap_s;
      rem_out_s  = rem_fix_s;
      ovf_out_s  = 1'b0;
      div0_out_s = 1'b0;
      if (zero_s) begin
`ifdef MYPROJECT_SDIV_SAT_EN
         if (dneg_q) begin
            dout_fix_s = Q_MIN;
         end else begin
            dout_fix_s = Q_MAX;
         end
`else
         dout_fix_s = {dout_WIDTH{1'b1}};
`endif
         rem_out_s  = {din1_WIDTH{1'b0}};
         div0_out_s = 1'b1;
      end else if (ovf_raw_s) begin
`ifdef MYPROJECT_SDIV_SAT_EN
         if (qneg_q) begin
            dout_fix_s = Q_MIN;
         end else begin
            dout_fix_s = Q_MAX;
         end
`else
         dout_fix_s = wrap_s;
`endif
         ovf_out_s = 1'b1;
      end else begin
         dout_fix_s = wrap_s;
      end
   end

   // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      prem_d  = prem_q;
      dsr_d   = dsr_q;
      qneg_d  = qneg_q;
      dneg_d  = dneg_q;
      dout_d  = dout_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      div0_d  = div0_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ap_start) begin
               dneg_d = bus.din0[din0_WIDTH-1];
               qneg_d = bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
               if (bus.din0[din0_WIDTH-1]) begin
                  dvd_d = ~bus.din0 + ONE_DVD;
               end else begin
                  dvd_d = bus.din0;
               end
               if (bus.din1[din1_WIDTH-1]) begin
                  dsr_d = ~bus.din1 + ONE_DSR;
               end else begin
                  dsr_d = bus.din1;
               end
               cnt_d   = {CW{1'b0}};
               prem_d  = {PW{1'b0}};
               quo_d   = {din0_WIDTH{1'b0}};
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            dvd_d = {dvd_q[din0_WIDTH-2:0], 1'b0};
            if (!trial_s[PW]) begin
               prem_d = trial_s[PW-1:0];
               quo_d  = {quo_q[din0_WIDTH-2:0], 1'b1};
            end else begin
               prem_d = shifted_s[PW-1:0];
               quo_d  = {quo_q[din0_WIDTH-2:0], 1'b0};
            end
            if (cnt_q == LAST_CNT) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end
         S_FIX: begin
            dout_d  = dout_fix_s;
            rem_d   = rem_out_s;
            ovf_d   = ovf_out_s;
            div0_d  = div0_out_s;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and result registers; reset aborts any division in flight.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         dvd_q   <= {din0_WIDTH{1'b0}};
         quo_q   <= {din0_WIDTH{1'b0}};
         prem_q  <= {PW{1'b0}};
         dsr_q   <= {din1_WIDTH{1'b0}};
         qneg_q  <= 1'b0;
         dneg_q  <= 1'b0;
         dout_q  <= {dout_WIDTH{1'b0}};
         rem_q   <= {din1_WIDTH{1'b0}};
         ovf_q   <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         prem_q  <= prem_d;
         dsr_q   <= dsr_d;
         qneg_q  <= qneg_d;
         dneg_q  <= dneg_d;
         dout_q  <= dout_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         div0_q  <= div0_d;
      end
   end

endmodule

// File: tb/tb_myproject_sdiv_26s_12s_14_seq.sv
// Bench for the sequential signed divider: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results (MYPROJECT_SDIV_SAT_EN selects the saturating build).
module tb_myproject_sdiv_26s_12s_14_seq;

   localparam int W0 = 26;
   localparam int W1 = 12;
   localparam int WQ = 14;
   localparam int RW = WQ + W1 + 2;

`ifdef MYPROJECT_SDIV_SAT_EN
   localparam logic signed [63:0] E_BIG_POS = 64'sd8191;
   localparam logic signed [63:0] E_MIN_NEG = 64'sd8191;
   localparam logic signed [63:0] E_DIV0    = -64'sd8192;
`else
   localparam logic signed [63:0] E_BIG_POS = -64'sd1;
   localparam logic signed [63:0] E_MIN_NEG = 64'sd0;
   localparam logic signed [63:0] E_DIV0    = -64'sd1;
`endif

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;

   myproject_sdiv_26s_12s_14_seq_if bus ();

   myproject_sdiv_26s_12s_14_seq u_dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus.slave)
   );

   always #5 ap_clk = ~ap_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result {dout, rem, ovf, div0} from plain signed arithmetic.
   function automatic logic [RW-1:0] model(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b);
      logic signed [63:0] la, lb, q, r, d;
      logic ov, z;
      la = a;
      lb = b;
      z  = (lb == 0);
      ov = 1'b0;
      if (z) begin
         r = 0;
`ifdef MYPROJECT_SDIV_SAT_EN
         d = (la >= 0) ? 64'sd8191 : -64'sd8192;
`else
         d = -64'sd1;
`endif
      end else begin
         q  = la / lb;
         r  = la % lb;
         ov = (q > 64'sd8191) || (q < -64'sd8192);
         d  = q;
`ifdef MYPROJECT_SDIV_SAT_EN
         if (ov) d = (q > 0) ? 64'sd8191 : -64'sd8192;
`endif
      end
      return {d[WQ-1:0], r[W1-1:0], ov, z};
   endfunction

   // Model timeline: accepts while idle, results appear 27 edges after accept.
   logic          m_idle    = 1'b1;
   int            edge_n    = 0;
   int            done_edge = -10;
   logic [RW-1:0] pend      = '0;
   logic [RW-1:0] held      = '0;

   initial begin
      forever begin
         @(posedge ap_clk or negedge ap_rst_n);
         if (!ap_rst_n) begin
            m_idle    = 1'b1;
            held      = '0;
            done_edge = -10;
         end else begin
            edge_n++;
            if (m_idle) begin
               if (bus.ap_start) begin
                  pend      = model(bus.din0, bus.din1);
                  done_edge = edge_n + 27;
                  m_idle    = 1'b0;
               end
            end else begin
               if (edge_n == done_edge) held = pend;
               else if (edge_n == done_edge + 1) m_idle = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of handshake and held results against the model.
   initial begin
      logic [2:0] exp_ctrl;
      forever begin
         @(negedge ap_clk);
         #1;
         exp_ctrl = {m_idle, (!m_idle && edge_n == done_edge), (m_idle & bus.ap_start)};
         check("ctrl_idle_done_ready", {61'd0, bus.ap_idle, bus.ap_done, bus.ap_ready}, {61'd0, exp_ctrl});
         check("results", {36'd0, bus.dout, bus.rem, bus.ovf, bus.div0}, {36'd0, held});
      end
   end

   task automatic do_op(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b, output int lat);
      @(negedge ap_clk);
      bus.din0     = a;
      bus.din1     = b;
      bus.ap_start = 1'b1;
      @(posedge ap_clk);
      lat = 0;
      while (lat < 60) begin
         @(negedge ap_clk);
         if (lat == 0) begin
            bus.ap_start = 1'b0;
            bus.din0     = W0'($urandom);
            bus.din1     = W1'($urandom);
         end
         if (bus.ap_done) break;
         @(posedge ap_clk);
         lat++;
      end
   endtask

   task automatic check_res(input string name, input logic signed [63:0] q, input logic signed [63:0] r,
                            input logic signed [63:0] o, input logic signed [63:0] z);
      check({name, "_dout"}, $signed(bus.dout), q);
      check({name, "_rem"},  $signed(bus.rem),  r);
      check({name, "_ovf"},  {63'd0, bus.ovf},  o);
      check({name, "_div0"}, {63'd0, bus.div0}, z);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int m;
      bus.ap_start = 1'b1;
      bus.din0     = '0;
      bus.din1     = '0;
      repeat (3) @(negedge ap_clk);
      check("rst_ready", {63'd0, bus.ap_ready}, 64'sd1);
      check("rst_idle",  {63'd0, bus.ap_idle},  64'sd1);
      check("rst_done",  {63'd0, bus.ap_done},  64'sd0);
      check_res("rst", 64'sd0, 64'sd0, 64'sd0, 64'sd0);
      bus.ap_start = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (2) @(negedge ap_clk);

      do_op(26'sd100000, 12'sd25, lat);
      check("t1_latency", lat, 64'sd27);
      check_res("t1", 64'sd4000, 64'sd0, 64'sd0, 64'sd0);

      // Back-to-back with start held high; operands change during CALC.
      @(negedge ap_clk);
      bus.din0     = -26'sd1003;
      bus.din1     = 12'sd7;
      bus.ap_start = 1'b1;
      @(posedge ap_clk);
      lat = 0;
      while (lat < 60) begin
         @(negedge ap_clk);
         if (lat == 0) begin
            bus.din0 = 26'sd7;
            bus.din1 = -12'sd2;
         end
         if (bus.ap_done) break;
         @(posedge ap_clk);
         lat++;
      end
      check("t2a_latency", lat, 64'sd27);
      check_res("t2a", -64'sd143, -64'sd2, 64'sd0, 64'sd0);
      m = 0;
      while (m < 60) begin
         @(posedge ap_clk);
         m++;
         @(negedge ap_clk);
         if (bus.ap_done) break;
      end
      bus.ap_start = 1'b0;
      check("t2b_spacing", m, 64'sd29);
      check_res("t2b", -64'sd3, 64'sd1, 64'sd0, 64'sd0);

      do_op(26'sd33554431, 12'sd1, lat);
      check("t3_latency", lat, 64'sd27);
      check_res("t3", E_BIG_POS, 64'sd0, 64'sd1, 64'sd0);

      do_op(-26'sd33554432, -12'sd2048, lat);
      check_res("t4", E_MIN_NEG, 64'sd0, 64'sd1, 64'sd0);

      do_op(-26'sd5, 12'sd0, lat);
      check_res("t5", E_DIV0, 64'sd0, 64'sd0, 64'sd1);

      // Reset ten cycles into CALC.
      @(negedge ap_clk);
      bus.din0     = 26'sd100000;
      bus.din1     = 12'sd25;
      bus.ap_start = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      repeat (10) @(posedge ap_clk);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("abort_idle", {63'd0, bus.ap_idle}, 64'sd1);
      check("abort_done", {63'd0, bus.ap_done}, 64'sd0);
      check_res("abort", 64'sd0, 64'sd0, 64'sd0, 64'sd0);
      repeat (3) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (2) @(negedge ap_clk);

      do_op(26'sd100000, 12'sd25, lat);
      check("t6_latency", lat, 64'sd27);
      check_res("t6", 64'sd4000, 64'sd0, 64'sd0, 64'sd0);

      repeat (3) @(negedge ap_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
